// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg: shared definitions for the core control sequencer.
//   - state_e          : control FSM state encoding
//   - TIMEOUT_DEFAULT  : default watchdog limit in wait cycles
//   - is_active()      : true for states that advance the cycle counter
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StMem    = 3'd3,
        StExec   = 3'd4,
        StHalt   = 3'd5,
        StErr    = 3'd6
    } state_e;

    function automatic logic is_active(input state_e s);
        return (s == StFetch) || (s == StDecode) || (s == StMem) || (s == StExec);
    endfunction

endpackage

// File: rtl/wdt.sv
// ---------------------------------------------------------------------------
// wdt: wait-cycle watchdog for IFU/LSU handshakes.
// Ports:
//   clk       in  core clock
//   rst_n     in  synchronous active-low reset
//   i_clear   in  force count to zero (asserted while not waiting)
//   i_enable  in  count one waiting cycle without a response
//   o_expire  out count has reached TIMEOUT-1 (combinational)
// ---------------------------------------------------------------------------
module wdt
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;

    assign o_expire = (r_cnt == LastCnt);

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_clear) begin
            w_cnt_d = '0;
        end else if (i_enable && !o_expire) begin
            // Saturate at the limit; the FSM leaves the wait state on expiry anyway.
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

endmodule

// File: rtl/core_ctrl.sv
// ---------------------------------------------------------------------------
// core_ctrl: multi-cycle core sequencer FETCH -> DECODE -> [MEM] -> EXEC.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   ifu_reqValid / ifu_respValid   fetch request / response
//   is_mem, is_halt                decode flags, valid in DECODE
//   lsu_reqValid / lsu_respValid   memory request / response
//   exu_reqValid / exu_respValid   execute-commit strobe / done
//   pc_wen, commit                 PC update and retire pulse (EXEC)
//   halted, fault                  sticky ebreak-retired / watchdog-expired
//   cycle_cnt, instret_cnt         64-bit active-cycle / retired counters
// ---------------------------------------------------------------------------
module core_ctrl
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_reqValid,
    input  logic        ifu_respValid,
    input  logic        is_mem,
    input  logic        is_halt,
    output logic        lsu_reqValid,
    input  logic        lsu_respValid,
    output logic        exu_reqValid,
    input  logic        exu_respValid,
    output logic        pc_wen,
    output logic        commit,
    output logic        halted,
    output logic        fault,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    state_e      r_state;
    state_e      w_state_d;
    logic        r_is_halt;
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;

    logic w_waiting;
    logic w_resp;
    logic w_expire;
    logic w_commit;

    // Stray responses outside their own wait state are masked here.
    assign w_waiting = (r_state == StFetch) || (r_state == StMem);
    assign w_resp    = ((r_state == StFetch) && ifu_respValid) ||
                       ((r_state == StMem)   && lsu_respValid);

    wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (!w_waiting),
        .i_enable (w_waiting && !w_resp),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   w_state_d = StFetch;
            StFetch: begin
                // A response on the expiry cycle takes priority over the fault.
                if (ifu_respValid) begin
                    w_state_d = StDecode;
                end else if (w_expire) begin
                    w_state_d = StErr;
                end
            end
            StDecode: w_state_d = is_mem ? StMem : StExec;
            StMem: begin
                if (lsu_respValid) begin
                    w_state_d = StExec;
                end else if (w_expire) begin
                    w_state_d = StErr;
                end
            end
            StExec: begin
                if (exu_respValid) begin
                    w_state_d = r_is_halt ? StHalt : StFetch;
                end
            end
            StHalt:   w_state_d = StHalt;
            StErr:    w_state_d = StErr;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_is_halt <= 1'b0;
        end else begin
            r_state <= w_state_d;
            // is_halt is only valid in DECODE; keep it for the EXEC exit decision.
            if (r_state == StDecode) begin
                r_is_halt <= is_halt;
            end
        end
    end

    assign w_commit = (r_state == StExec);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (is_active(r_state)) begin
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
            end
            if (w_commit) begin
                r_instret_cnt <= r_instret_cnt + 64'd1;
            end
        end
    end

    // Requests are gated by rst_n so nothing is issued while reset is held.
    assign ifu_reqValid = rst_n && (r_state == StFetch);
    assign lsu_reqValid = rst_n && (r_state == StMem);
    assign exu_reqValid = rst_n && w_commit;
    assign pc_wen       = rst_n && w_commit;
    assign commit       = rst_n && w_commit;
    assign halted       = (r_state == StHalt);
    assign fault        = (r_state == StErr);
    assign cycle_cnt    = r_cycle_cnt;
    assign instret_cnt  = r_instret_cnt;

endmodule

// File: tb/tb_core_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_ctrl: directed self-checking bench for core_ctrl (TIMEOUT=8).
// ---------------------------------------------------------------------------
module tb_core_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_reqValid, ifu_respValid;
    logic        is_mem, is_halt;
    logic        lsu_reqValid, lsu_respValid;
    logic        exu_reqValid, exu_respValid;
    logic        pc_wen, commit, halted, fault;
    logic [63:0] cycle_cnt, instret_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_ctrl #(
        .TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_respValid (ifu_respValid),
        .is_mem        (is_mem),
        .is_halt       (is_halt),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_respValid (lsu_respValid),
        .exu_reqValid  (exu_reqValid),
        .exu_respValid (exu_respValid),
        .pc_wen        (pc_wen),
        .commit        (commit),
        .halted        (halted),
        .fault         (fault),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst_n         = 1'b0;
        ifu_respValid = 1'b0;
        is_mem        = 1'b0;
        is_halt       = 1'b0;
        lsu_respValid = 1'b0;
        exu_respValid = 1'b1;

        // Reset state
        do_reset();
        check("rst_ifu", ifu_reqValid, 0);
        check("rst_lsu", lsu_reqValid, 0);
        check("rst_exu", {exu_reqValid, pc_wen, commit}, 0);
        check("rst_flags", {halted, fault}, 0);
        check("rst_cycle", cycle_cnt, 0);
        check("rst_instret", instret_cnt, 0);

        // Zero-wait ALU instructions
        ifu_respValid = 1'b1;
        rst_n = 1'b1;
        step();
        check("alu_fetch_req", ifu_reqValid, 1);
        check("alu_fetch_cycle", cycle_cnt, 0);
        step();
        check("alu_decode_req", {ifu_reqValid, lsu_reqValid, exu_reqValid}, 3'b000);
        step();
        check("alu_exec_strobes", {exu_reqValid, pc_wen, commit}, 3'b111);
        check("alu_exec_excl", {ifu_reqValid, lsu_reqValid}, 2'b00);
        check("alu_exec_instret", instret_cnt, 0);
        step();
        check("alu_instret_1", instret_cnt, 1);
        check("alu_cycle_3", cycle_cnt, 3);
        for (int i = 0; i < 6; i++) begin
            check("alu_commit_pattern", commit, (i % 3 == 2) ? 1 : 0);
            check("alu_fetch_pattern", ifu_reqValid, (i % 3 == 0) ? 1 : 0);
            step();
        end
        check("alu_cycle_9", cycle_cnt, 9);
        check("alu_instret_3", instret_cnt, 3);

        // Load with 5 wait cycles
        do_reset();
        is_mem = 1'b1;
        rst_n = 1'b1;
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("ld_wait_lsu", lsu_reqValid, 1);
            check("ld_wait_commit", commit, 0);
            step();
        end
        lsu_respValid = 1'b1;
        check("ld_last_lsu", lsu_reqValid, 1);
        step();
        lsu_respValid = 1'b1;   // stray, must be ignored in EXEC
        check("ld_exec_commit", commit, 1);
        check("ld_exec_lsu", lsu_reqValid, 0);
        step();
        lsu_respValid = 1'b0;
        check("ld_cycle_9", cycle_cnt, 9);
        check("ld_instret_1", instret_cnt, 1);
        check("ld_back_fetch", ifu_reqValid, 1);

        // Reset in the middle of MEM
        step();
        step();
        check("mid_mem_lsu", lsu_reqValid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_lsu_gated", lsu_reqValid, 0);
        step();
        check("mid_rst_cycle", cycle_cnt, 0);
        check("mid_rst_instret", instret_cnt, 0);
        check("mid_rst_idle", {ifu_reqValid, lsu_reqValid, commit}, 3'b000);
        is_mem = 1'b0;
        rst_n = 1'b1;
        step();
        check("mid_rst_fetch", ifu_reqValid, 1);

        // ebreak
        is_halt = 1'b1;
        step();
        step();
        check("halt_commit", commit, 1);
        step();
        is_halt = 1'b0;
        check("halt_flag", halted, 1);
        check("halt_no_commit", commit, 0);
        for (int i = 0; i < 100; i++) step();
        check("halt_cycle_frozen", cycle_cnt, 3);
        check("halt_instret", instret_cnt, 1);
        check("halt_sticky", {halted, ifu_reqValid, lsu_reqValid, exu_reqValid}, 4'b1000);

        // Watchdog expiry on fetch
        ifu_respValid = 1'b0;
        do_reset();
        check("halt_cleared", halted, 0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            check("wdt_fetch_req", ifu_reqValid, 1);
            check("wdt_no_fault", fault, 0);
            step();
        end
        check("wdt_fault", fault, 1);
        check("wdt_err_req", ifu_reqValid, 0);
        step();
        step();
        check("wdt_cycle_frozen", cycle_cnt, 8);
        check("wdt_fault_sticky", fault, 1);

        // Response on the expiry cycle wins
        do_reset();
        check("fault_cleared", fault, 0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 7; i++) step();
        ifu_respValid = 1'b1;
        check("late_fetch_req", ifu_reqValid, 1);
        step();
        check("late_decode_fault", fault, 0);
        check("late_decode_req", {ifu_reqValid, exu_reqValid}, 2'b00);
        step();
        check("late_exec_commit", commit, 1);
        step();
        check("late_fetch_again", ifu_reqValid, 1);

        // Counter wrap
        force dut.r_cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.r_cycle_cnt;
        step();
        check("wrap_max", cycle_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("wrap_zero", cycle_cnt, 0);
        check("wrap_exec", commit, 1);
        step();
        check("wrap_one", cycle_cnt, 1);
        check("wrap_fetch", ifu_reqValid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
